// File: rtl/seven_segment_to_hex_capture.sv
// seven_segment_to_hex_capture
// Reads back a bank of active-low seven-segment patterns as hex nibbles.
// One digit is scanned per cycle; a digit's decoded value is committed only
// after its pattern has been seen unchanged for STABLE_CYCLES consecutive
// scans. Each full scan ends with a one-cycle frame_done strobe, and
// changed reports whether any committed digit moved during that frame.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | not scanning; committed outputs and counters held
//   S_SCAN   | sampling digit idx, updating its filter, idx advances
//   S_COMMIT | frame boundary: frame_done pulse, changed published
module seven_segment_to_hex_capture #(
  parameter int NUM_DIGITS    = 8,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    enable,
  input  logic [7*NUM_DIGITS-1:0] seg_in,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_blank,
  output logic                    frame_done,
  output logic                    changed
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NUM_DIGITS-1:0][6:0]          last_q, last_d;
  logic [NUM_DIGITS-1:0][CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]          hex_q, hex_d;
  logic [NUM_DIGITS-1:0]               valid_q, valid_d;
  logic [NUM_DIGITS-1:0]               blank_q, blank_d;
  logic                                chg_q, chg_d;

  logic [NUM_DIGITS-1:0][6:0]          seg_arr;
  logic [6:0]                          pat;
  logic [5:0]                          dec;
  logic [CNT_W-1:0]                    cnt_upd;

  // Decoded result packed as {valid, blank, nibble}; bit order of the
  // pattern is g..a, 0 = segment lit.
  function automatic logic [5:0] decode(input logic [6:0] p);
    case (p)
      7'b1000000: decode = {2'b10, 4'h0};
      7'b1111001: decode = {2'b10, 4'h1};
      7'b0100100: decode = {2'b10, 4'h2};
      7'b0110000: decode = {2'b10, 4'h3};
      7'b0011001: decode = {2'b10, 4'h4};
      7'b0010010: decode = {2'b10, 4'h5};
      7'b0000010: decode = {2'b10, 4'h6};
      7'b1111000: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0011000: decode = {2'b10, 4'h9};
      7'b0001000: decode = {2'b10, 4'hA};
      7'b0000011: decode = {2'b10, 4'hB};
      7'b1000110: decode = {2'b10, 4'hC};
      7'b0100001: decode = {2'b10, 4'hD};
      7'b0000110: decode = {2'b10, 4'hE};
      7'b0001110: decode = {2'b10, 4'hF};
      7'h7F:      decode = {2'b01, 4'h0};
      default:    decode = {2'b00, 4'h0};
    endcase
  endfunction

  assign seg_arr = seg_in;
  assign pat     = seg_arr[idx_q];
  assign dec     = decode(pat);

  // Next-state logic: scan sequencing plus the per-digit stability filter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    valid_d = valid_q;
    blank_d = blank_q;
    chg_d   = chg_q;
    cnt_upd = cnt_q[idx_q];

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end

      S_SCAN: begin
        if (pat == last_q[idx_q]) begin
          cnt_upd = (cnt_q[idx_q] == CNT_MAX) ? CNT_MAX : cnt_q[idx_q] + 1'b1;
        end else begin
          cnt_upd       = CNT_W'(1);
          last_d[idx_q] = pat;
        end
        cnt_d[idx_q] = cnt_upd;

        // A saturated digit is rewritten every frame; only a real
        // difference in the committed fields marks the frame as changed.
        if (cnt_upd == CNT_MAX) begin
          hex_d[idx_q]   = dec[3:0];
          valid_d[idx_q] = dec[5];
          blank_d[idx_q] = dec[4];
          if ((hex_q[idx_q] != dec[3:0]) || (valid_q[idx_q] != dec[5]) ||
              (blank_q[idx_q] != dec[4])) begin
            chg_d = 1'b1;
          end
        end

        if (idx_q == LAST_IDX) begin
          state_d = S_COMMIT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      S_COMMIT: begin
        chg_d   = 1'b0;
        idx_d   = '0;
        state_d = enable ? S_SCAN : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State and committed-digit registers; reset aborts any frame in flight.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= {NUM_DIGITS{7'h7F}};
      cnt_q   <= '0;
      hex_q   <= '0;
      valid_q <= '0;
      blank_q <= '0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      valid_q <= valid_d;
      blank_q <= blank_d;
      chg_q   <= chg_d;
    end
  end

  assign hex_out     = hex_q;
  assign digit_valid = valid_q;
  assign digit_blank = blank_q;
  assign frame_done  = (state_q == S_COMMIT);
  assign changed     = frame_done & chg_q;

endmodule

// File: tb/tb_seven_segment_to_hex_capture.sv
// Bench for seven_segment_to_hex_capture (8 digits, 4-scan filter).
// Stimulus queues the expected per-frame result; the monitor pops one entry
// on every frame_done and also drains a queue of direct point checks.
module tb_seven_segment_to_hex_capture;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        enable;
  logic [55:0] seg_in;
  logic [31:0] hex_out;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_blank;
  logic        frame_done;
  logic        changed;

  seven_segment_to_hex_capture #(.NUM_DIGITS(8), .STABLE_CYCLES(4)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .enable     (enable),
    .seg_in     (seg_in),
    .hex_out    (hex_out),
    .digit_valid(digit_valid),
    .digit_blank(digit_blank),
    .frame_done (frame_done),
    .changed    (changed)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0] hex;
    logic [7:0]  vld;
    logic [7:0]  blk;
    logic        chg;
  } exp_t;

  typedef struct packed {
    logic [7:0]  code;
    logic [31:0] act;
    logic [31:0] req;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dchk_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    frame_no = 0;
  exp_t  e;
  dchk_t d;

  function automatic string cname(input logic [7:0] c);
    case (c)
      8'd1:    cname = "frame_timeout";
      8'd2:    cname = "reset_hex_out";
      8'd3:    cname = "reset_digit_valid";
      8'd4:    cname = "reset_digit_blank";
      8'd5:    cname = "reset_frame_done";
      8'd6:    cname = "reset_changed";
      8'd7:    cname = "drain_latency";
      8'd8:    cname = "idle_pulse_count";
      8'd9:    cname = "idle_hex_hold";
      8'd10:   cname = "idle_valid_hold";
      8'd11:   cname = "async_reset_hex";
      8'd12:   cname = "async_reset_valid";
      8'd13:   cname = "async_reset_frame_done";
      8'd14:   cname = "expect_queue_empty";
      default: cname = "unknown";
    endcase
  endfunction

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0011000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [55:0] disp(input logic [31:0] h);
    logic [55:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s[7*i +: 7] = glyph(h[4*i +: 4]);
    return s;
  endfunction

  // Monitor: scoreboard pop on frame_done, changed qualification, point checks.
  always @(negedge Clock) begin
    if (frame_done) begin
      frame_no++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_frame_done: frame %0d pulsed, none required", frame_no);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (hex_out !== e.hex) begin
          n_fail++;
          $display("FAIL hex_out frame %0d: got %h required %h", frame_no, hex_out, e.hex);
        end
        n_checks++;
        if (digit_valid !== e.vld) begin
          n_fail++;
          $display("FAIL digit_valid frame %0d: got %h required %h", frame_no, digit_valid, e.vld);
        end
        n_checks++;
        if (digit_blank !== e.blk) begin
          n_fail++;
          $display("FAIL digit_blank frame %0d: got %h required %h", frame_no, digit_blank, e.blk);
        end
        n_checks++;
        if (changed !== e.chg) begin
          n_fail++;
          $display("FAIL changed frame %0d: got %b required %b", frame_no, changed, e.chg);
        end
      end
    end else begin
      n_checks++;
      if (changed !== 1'b0) begin
        n_fail++;
        $display("FAIL changed_unqualified: got %b required 0", changed);
      end
    end
    while (dchk_q.size() > 0) begin
      d = dchk_q.pop_front();
      n_checks++;
      if (d.act !== d.req) begin
        n_fail++;
        $display("FAIL %s: got %h required %h", cname(d.code), d.act, d.req);
      end
    end
  end

  task automatic point(input logic [7:0] code, input logic [31:0] act, input logic [31:0] req);
    dchk_q.push_back({code, act, req});
  endtask

  task automatic wait_fd();
    bit got = 1'b0;
    int n = 0;
    while (!got && n < 40) begin
      @(negedge Clock);
      n++;
      if (frame_done) got = 1'b1;
    end
    if (!got) point(8'd1, 32'd0, 32'd1);
  endtask

  task automatic expect_frame(input logic [31:0] h, input logic [7:0] v,
                              input logic [7:0] b, input logic c);
    exp_q.push_back({h, v, b, c});
    wait_fd();
  endtask

  task automatic expect_n(input int n, input logic [31:0] h, input logic [7:0] v,
                          input logic [7:0] b);
    for (int i = 0; i < n; i++) expect_frame(h, v, b, 1'b0);
  endtask

  initial begin
    logic [55:0] s;
    int cyc;
    int pulses;
    bit got;

    Resetn = 1'b0;
    enable = 1'b0;
    seg_in = {8{7'h7F}};
    repeat (2) @(posedge Clock);
    #1;
    point(8'd2, hex_out, 32'h0);
    point(8'd3, {24'h0, digit_valid}, 32'h0);
    point(8'd4, {24'h0, digit_blank}, 32'h0);
    point(8'd5, {31'h0, frame_done}, 32'h0);
    point(8'd6, {31'h0, changed}, 32'h0);

    // All digits show "0": commit on the 4th frame, then quiet.
    seg_in = disp(32'h0);
    enable = 1'b1;
    @(posedge Clock);
    #1 Resetn = 1'b1;
    expect_n(3, 32'h0, 8'h00, 8'h00);
    expect_frame(32'h0, 8'hFF, 8'h00, 1'b1);
    expect_frame(32'h0, 8'hFF, 8'h00, 1'b0);

    // 1..8 across digits 7..0.
    seg_in = disp(32'h12345678);
    expect_n(3, 32'h0, 8'hFF, 8'h00);
    expect_frame(32'h12345678, 8'hFF, 8'h00, 1'b1);

    // Digit 0 blanked, then an illegal pattern.
    s = disp(32'h12345678);
    s[6:0] = 7'h7F;
    seg_in = s;
    expect_n(3, 32'h12345678, 8'hFF, 8'h00);
    expect_frame(32'h12345670, 8'hFE, 8'h01, 1'b1);
    s[6:0] = 7'b1010101;
    seg_in = s;
    expect_n(3, 32'h12345670, 8'hFE, 8'h01);
    expect_frame(32'h12345670, 8'hFE, 8'h00, 1'b1);

    // Restore, then a one-frame glitch on digit 3 that must never surface.
    seg_in = disp(32'h12345678);
    expect_n(3, 32'h12345670, 8'hFE, 8'h00);
    expect_frame(32'h12345678, 8'hFF, 8'h00, 1'b1);
    expect_frame(32'h12345678, 8'hFF, 8'h00, 1'b0);
    s = disp(32'h12345678);
    s[27:21] = 7'b0000000;
    seg_in = s;
    expect_frame(32'h12345678, 8'hFF, 8'h00, 1'b0);
    seg_in = disp(32'h12345678);
    expect_n(5, 32'h12345678, 8'hFF, 8'h00);

    // Drop enable at idx 3: frame drains in 5 cycles, then idle.
    repeat (4) @(posedge Clock);
    #1 enable = 1'b0;
    exp_q.push_back({32'h12345678, 8'hFF, 8'h00, 1'b0});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge Clock);
      cyc++;
      @(negedge Clock);
      if (frame_done) got = 1'b1;
    end
    point(8'd7, cyc, 32'd5);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (frame_done) pulses++;
    end
    point(8'd8, pulses, 32'd0);
    point(8'd9, hex_out, 32'h12345678);
    point(8'd10, {24'h0, digit_valid}, 32'h0000_00FF);

    // Commit ABCDEF01, then reset at idx 5 of the following frame.
    seg_in = disp(32'hABCDEF01);
    enable = 1'b1;
    expect_n(3, 32'h12345678, 8'hFF, 8'h00);
    expect_frame(32'hABCDEF01, 8'hFF, 8'h00, 1'b1);
    repeat (6) @(posedge Clock);
    #1 Resetn = 1'b0;
    #1;
    point(8'd11, hex_out, 32'h0);
    point(8'd12, {24'h0, digit_valid}, 32'h0);
    point(8'd13, {31'h0, frame_done}, 32'h0);
    repeat (2) @(posedge Clock);
    #1 Resetn = 1'b1;
    expect_n(3, 32'h0, 8'h00, 8'h00);
    expect_frame(32'hABCDEF01, 8'hFF, 8'h00, 1'b1);
    enable = 1'b0;

    repeat (20) @(negedge Clock);
    point(8'd14, exp_q.size(), 32'd0);
    repeat (3) @(negedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
